// File: rtl/mac_pe.sv
// -----------------------------------------------------------------------------
// mac_pe : multiply-accumulate processing element for the CNN PE array.
//
// Sums KERNEL_LEN signed featuremap*weight products for each output pixel.
// The sum is then shifted right by FRAC_BITS (floor), saturated to OUT_W bits
// and emitted with a one-cycle valid strobe. The last pair of a window
// appears on the output two clock edges after it is accepted.
//
// Optional build macro:
//   MAC_PE_RELU_EN  when defined, a ReLU is applied after saturation. A
//                   negative result becomes 0 with sat_flag cleared.
//
// Ports:
//   clk                in   rising-edge clock
//   reset              in   synchronous, active-high; overrides start
//   start              in   enable; low flushes the pipeline and the window
//   in_valid           in   operand pair valid this cycle
//   input_featuremap   in   [DATA_W]   signed activation
//   weight             in   [WEIGHT_W] signed weight
//   out_valid          out  one-cycle strobe, output_featuremap is new
//   output_featuremap  out  [OUT_W] signed requantised result
//   sat_flag           out  result was clipped, valid with out_valid
//   busy               out  window partly accumulated or product in flight
// -----------------------------------------------------------------------------
module mac_pe #(
  parameter int DATA_W     = 16,
  parameter int WEIGHT_W   = 16,
  parameter int OUT_W      = 16,
  parameter int FRAC_BITS  = 10,
  parameter int KERNEL_LEN = 9,
  parameter int ACC_W      = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   input_featuremap,
  input  logic signed [WEIGHT_W-1:0] weight,
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    output_featuremap,
  output logic                       sat_flag,
  output logic                       busy
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int CNT_W  = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERNEL_LEN - 1);

  // Output range limits, written in accumulator width so they compare
  // directly against the shifted sum.
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Stage 1: product register
  logic signed [PROD_W-1:0] prod;
  logic                     p_valid;

  // Stage 2: window accumulator
  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  cnt;
  logic signed [ACC_W-1:0]  sum;
  logic                     last_tap;

  // Completed window sum, handed to the output stage
  logic signed [ACC_W-1:0]  s_sum;
  logic                     s_valid;

  // Stage 3: requantisation
  logic signed [ACC_W-1:0]  q;
  logic signed [OUT_W-1:0]  res;
  logic                     res_sat;

  // The first tap of a window starts from zero rather than from acc. The
  // accumulator therefore never needs a clear cycle between windows.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum      = '0;
    last_tap = 1'b0;
    sum      = ((cnt == '0) ? '0 : acc) + ACC_W'(prod);
    last_tap = (cnt == LAST_TAP);
  end

  // Arithmetic shift floors toward -inf. Clipping happens only here.
  always_comb begin
    res     = '0;
    res_sat = 1'b0;
    q       = s_sum >>> FRAC_BITS;
    if (q > OUT_MAX) begin
      res     = OUT_MAX[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (q < OUT_MIN) begin
      res     = OUT_MIN[OUT_W-1:0];
      res_sat = 1'b1;
    end else begin
      res     = q[OUT_W-1:0];
      res_sat = 1'b0;
    end
`ifdef MAC_PE_RELU_EN
    // A negative clip is no longer a clip once ReLU maps it to zero.
    if (res[OUT_W-1]) begin
      res     = '0;
      res_sat = 1'b0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod              <= '0;
      p_valid           <= 1'b0;
      acc               <= '0;
      cnt               <= '0;
      s_sum             <= '0;
      s_valid           <= 1'b0;
      out_valid         <= 1'b0;
      output_featuremap <= '0;
      sat_flag          <= 1'b0;
    end else if (!start) begin
      // The flush drops any partial window. The last result stays visible.
      prod      <= '0;
      p_valid   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      s_valid   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // Stage 1
      p_valid <= in_valid;
      if (in_valid) begin
        prod <= input_featuremap * weight;
      end

      // Stage 2: acc and cnt hold across gaps in p_valid.
      s_valid <= p_valid && last_tap;
      if (p_valid) begin
        if (last_tap) begin
          s_sum <= sum;
          cnt   <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end

      // Stage 3
      out_valid <= s_valid;
      if (s_valid) begin
        output_featuremap <= res;
        sat_flag          <= res_sat;
      end
    end
  end

  assign busy = p_valid | (cnt != '0);

endmodule

// File: tb/tb_mac_pe.sv
// -----------------------------------------------------------------------------
// tb_mac_pe : directed self-checking bench for mac_pe (default parameters).
// Expected values are hand-computed; MAC_PE_RELU_EN selects the ReLU variants.
// -----------------------------------------------------------------------------
module tb_mac_pe;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               in_valid;
  logic signed [15:0] input_featuremap;
  logic signed [15:0] weight;
  logic               out_valid;
  logic signed [15:0] output_featuremap;
  logic               sat_flag;
  logic               busy;

  mac_pe dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .in_valid          (in_valid),
    .input_featuremap  (input_featuremap),
    .weight            (weight),
    .out_valid         (out_valid),
    .output_featuremap (output_featuremap),
    .sat_flag          (sat_flag),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;

  typedef struct {
    int                 at_edge;
    logic signed [15:0] data;
    logic               sat;
  } res_t;

  res_t results[$];

  // Capture every output strobe together with the edge that produced it.
  always @(negedge clk) begin
    if (out_valid) begin
      results.push_back('{edge_n, output_featuremap, sat_flag});
    end
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, settle past it.
  task automatic drive(input bit v, input int a, input int w);
    in_valid         = v;
    input_featuremap = 16'(a);
    weight           = 16'(w);
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic window(input int a, input int w, input bit gaps, output int last);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, a, w);
      if (i == 8) last = edge_n;
      if (gaps && i < 8) drive(1'b0, 0, 0);
    end
  endtask

  task automatic expect_one(input string tag, input int last,
                            input int exp_d, input bit exp_s);
    repeat (3) drive(1'b0, 0, 0);
    check({tag, " count"}, results.size(), 1);
    if (results.size() > 0) begin
      check({tag, " latency"}, results[0].at_edge, last + 2);
      check({tag, " data"},    results[0].data,    exp_d);
      check({tag, " sat"},     results[0].sat,     exp_s);
    end
    results.delete();
  endtask

  initial begin
    int last;
    int l1;
    int l2;

    reset            = 1'b1;
    start            = 1'b1;
    in_valid         = 1'b0;
    input_featuremap = '0;
    weight           = '0;

    // Reset held two cycles with live random operands.
    repeat (2) drive(1'b1, int'($urandom), int'($urandom));
    check("rst out_valid", out_valid, 0);
    check("rst output", output_featuremap, 0);
    check("rst sat", sat_flag, 0);
    check("rst busy", busy, 0);
    reset = 1'b0;
    results.delete();

    // Eight pairs must not complete a window.
    repeat (8) drive(1'b1, 1024, 1024);
    repeat (3) drive(1'b0, 0, 0);
    check("early count", results.size(), 0);
    check("partial busy", busy, 1);
    drive(1'b1, 1024, 1024);
    last = edge_n;
    expect_one("first_win", last, 9216, 1'b0);

    // Nominal.
    window(1024, 1024, 1'b0, last);
    expect_one("nominal", last, 9216, 1'b0);

    // Floor and sign.
`ifdef MAC_PE_RELU_EN
    window(-1, 1, 1'b0, last);
    expect_one("floor", last, 0, 1'b0);
    window(-2048, 1024, 1'b0, last);
    expect_one("neg", last, 0, 1'b0);
`else
    window(-1, 1, 1'b0, last);
    expect_one("floor", last, -1, 1'b0);
    window(-2048, 1024, 1'b0, last);
    expect_one("neg", last, -18432, 1'b0);
`endif

    // Saturation.
    window(32767, 32767, 1'b0, last);
    expect_one("sat_pos", last, 32767, 1'b1);
`ifdef MAC_PE_RELU_EN
    window(-32768, 32767, 1'b0, last);
    expect_one("sat_neg", last, 0, 1'b0);
`else
    window(-32768, 32767, 1'b0, last);
    expect_one("sat_neg", last, -32768, 1'b1);
`endif

    // Gapped window followed back-to-back by a second window.
    window(1024, 1024, 1'b1, l1);
    window(512, 1024, 1'b0, l2);
    repeat (3) drive(1'b0, 0, 0);
    check("b2b count", results.size(), 2);
    if (results.size() > 1) begin
      check("gap latency", results[0].at_edge, l1 + 2);
      check("gap data", results[0].data, 9216);
      check("b2b latency", results[1].at_edge, l2 + 2);
      check("b2b spacing", results[1].at_edge - results[0].at_edge, 9);
      check("b2b data", results[1].data, 4608);
    end
    results.delete();

    // Flush mid-window.
    repeat (5) drive(1'b1, 1024, 1024);
    start = 1'b0;
    drive(1'b1, 1024, 1024);
    check("flush busy", busy, 0);
    check("flush out_valid", out_valid, 0);
    check("flush hold", output_featuremap, 4608);
    start = 1'b1;
    window(1024, 1024, 1'b0, last);
    expect_one("post_flush", last, 9216, 1'b0);

    // Negative result passes through, or clamps to zero under ReLU.
    window(-1024, 1024, 1'b0, last);
`ifdef MAC_PE_RELU_EN
    expect_one("relu", last, 0, 1'b0);
`else
    expect_one("negpass", last, -9216, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_pe.md
Name: mac_pe

Overview:
- Parametrised multiply-accumulate processing element for the CNN datapath; next generation of the single-product PE.
- Accumulates KERNEL_LEN signed fixed-point products per output pixel.
- Requantises the sum by FRAC_BITS with saturation and emits one result per kernel window with a valid strobe.
- Sits in the PE array between the featuremap/weight feeders and the output buffer.

Parameters:
- DATA_W, 16, featuremap operand width (signed)
- WEIGHT_W, 16, weight operand width (signed)
- OUT_W, 16, output featuremap width (signed)
- FRAC_BITS, 10, fractional bits removed from the accumulated sum
- KERNEL_LEN, 9, products per output (at least 1)
- ACC_W, 40, accumulator width; must be at least DATA_W+WEIGHT_W+clog2(KERNEL_LEN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  enable; low = synchronous flush of pipeline and window state
- in_valid  in  1  operand pair valid this cycle
- input_featuremap  in  DATA_W  signed activation
- weight  in  WEIGHT_W  signed weight
- out_valid  out  1  one-cycle strobe: output_featuremap is new
- output_featuremap  out  OUT_W  signed requantised result
- sat_flag  out  1  result was clipped; valid with out_valid
- busy  out  1  window partially accumulated or products in flight

Behaviour:
- Reset (reset=1 at a clk edge) clears everything: out_valid=0, output_featuremap=0, sat_flag=0, busy=0, product register 0, accumulator 0, tap counter 0. Reset takes priority over start.
- start=0 (reset=0):
  - Clears the product stage, accumulator, tap counter, out_valid and busy.
  - output_featuremap and sat_flag hold their last values.
  - A partial window is discarded and produces no out_valid.
- Stage 1 (product):
  - If start & in_valid: prod <= input_featuremap*weight (full DATA_W+WEIGHT_W, signed) and p_valid <= 1.
  - Otherwise p_valid <= 0.
- Stage 2 (accumulate), on p_valid only:
  - sum = (cnt==0 ? 0 : acc) + sign-extended prod.
  - If cnt < KERNEL_LEN-1: acc <= sum, cnt <= cnt+1.
  - If cnt == KERNEL_LEN-1: sum passes to stage 3, cnt <= 0.
  - With no p_valid, acc and cnt hold, so gaps in in_valid are allowed.
- Stage 3 (output register):
  - q = sum >>> FRAC_BITS (arithmetic shift, floor toward -inf, no rounding).
  - If q > 2^(OUT_W-1)-1: output 2^(OUT_W-1)-1, sat_flag=1.
  - If q < -2^(OUT_W-1): output -2^(OUT_W-1), sat_flag=1.
  - Otherwise output q[OUT_W-1:0], sat_flag=0.
  - out_valid=1 for exactly one cycle.
- Latency: in_valid of the KERNEL_LEN-th pair at edge t gives out_valid=1 after edge t+2, i.e. visible in the cycle following edge t+2.
- Throughput: one pair per cycle. Back-to-back windows need no bubble; the first pair of the next window may arrive the cycle after the last pair of the previous one.
- KERNEL_LEN=1: every valid pair produces a result. The counter never leaves 0.
- busy = p_valid | (cnt != 0).
- Accumulator never wraps within a window, given the ACC_W constraint. Clipping occurs only at requantisation.

Optional Feature:
- Macro: MAC_PE_RELU_EN.
- Defined: stage 3 applies ReLU after saturation. A negative result outputs 0 with sat_flag=0; a positive clip still sets sat_flag. Latency unchanged.
- Undefined: signed result passes unmodified. Negative outputs are allowed.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 and random operands -> out_valid=0, output_featuremap=0, sat_flag=0, busy=0; first out_valid only after 9 valid pairs following reset release.
- Nominal: start=1; 9 consecutive pairs a=1024, w=1024 -> exactly one out_valid, 3 cycles after the 9th pair, output=9216, sat_flag=0.
- Floor and sign: 9 pairs a=-1, w=1 -> output=-1 (0xFFFF). 9 pairs a=-2048, w=1024 -> output=-18432.
- Saturation: 9 pairs a=32767, w=32767 -> 32767 with sat_flag=1. 9 pairs a=-32768, w=32767 -> -32768 with sat_flag=1.
- Gaps and back-to-back:
  - 9 pairs of 1024/1024 with in_valid toggling every other cycle -> output 9216.
  - Immediately after, 9 pairs a=512, w=1024 with no bubble -> second out_valid exactly 9 cycles after the first, output=4608.
- Flush mid-window: 5 pairs, then start=0 for 1 cycle, then 9 pairs of 1024/1024 -> no out_valid for the partial window, next output=9216. With MAC_PE_RELU_EN defined, 9 pairs a=-1024, w=1024 -> output=0, sat_flag=0.
